// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the 16-bit sensor/alarm serial link receiver:
// frame geometry, fixed-bit mask/value, flag bit positions, FSM states.
package serial_frame_receiver_pkg;

  localparam int          FRAME_W    = 16;
  localparam logic [15:0] FIXED_MASK = 16'hFC07;
  localparam logic [15:0] FIXED_VAL  = 16'hF803;

  // Flag positions inside the frame word
  localparam int BIT_HUMO  = 3;
  localparam int BIT_POS   = 4;
  localparam int BIT_TEMPG = 5;
  localparam int BIT_TEMPL = 6;
  localparam int BIT_FREC  = 7;
  localparam int BIT_ALL   = 8;
  localparam int BIT_ALG   = 9;
  localparam int FLAG_LSB  = BIT_HUMO;
  localparam int N_FLAGS   = BIT_ALG - BIT_HUMO + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  // Packed so that the struct lines up with frame bits 9..3
  typedef struct packed {
    logic alg;
    logic all;
    logic frec;
    logic templ;
    logic tempg;
    logic pos;
    logic humo;
  } rx_flags_t;

  // True when the fixed header/trailer bits of a frame word are present
  function automatic logic frame_match(input logic [FRAME_W-1:0] w);
    return (w & FIXED_MASK) == FIXED_VAL;
  endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Link-side bundle of the serial frame receiver: serial input plus the
// recovered flags and status pulses. master = link/monitor side,
// slave = receiver.
interface serial_frame_receiver_if;
  logic Dserie;
  logic humo;
  logic pos;
  logic tempG;
  logic tempL;
  logic frec;
  logic alL;
  logic alG;
  logic frame_valid;
  logic frame_err;
  logic locked;

  modport master (
    output Dserie,
    input  humo, pos, tempG, tempL, frec, alL, alG,
    input  frame_valid, frame_err, locked
  );

  modport slave (
    input  Dserie,
    output humo, pos, tempG, tempL, frec, alL, alG,
    output frame_valid, frame_err, locked
  );
endinterface

// File: rtl/frame_bit_counter.sv
// 4-bit frame bit position counter: async active-low reset, synchronous
// clear (wins over enable), wraps 15 -> 0.
module frame_bit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt
);

  // Count bit slots; clear realigns the count to a newly found frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= 4'd0;
    else if (clr) cnt <= 4'd0;
    else if (en)  cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: finds 16-bit frame alignment from the fixed
// header/trailer bits, qualifies lock over LOCK_FRAMES frames, drops lock
// after UNLOCK_ERRS consecutive bad frames, and presents the seven status
// flags as registered outputs.
// Build option: define RX_INPUT_SYNC_EN to pass Dserie through a 2-flop
// synchronizer (adds 2 clk latency) when the link comes from another clock.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int UNLOCK_ERRS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_frame_receiver_if.slave bus
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  logic                 din;
  // Window bit 0 leaves on the next shift, so only bits 15..1 are stored
  logic [FRAME_W-1:1]   sr;
  logic [FRAME_W-1:0]   win;
  logic [3:0]           fill_cnt;
  logic                 fill_done;
  logic                 match;
  logic [3:0]           bcnt;
  logic                 boundary;
  logic                 bcnt_clr;
  rx_state_t            state;
  logic [2:0]           good;
  logic [2:0]           errs;
  logic [3:0]           good_nxt;
  logic [3:0]           errs_nxt;
  rx_flags_t            flags;
  rx_flags_t            win_flags;
  logic                 frame_valid;
  logic                 frame_err;
  logic                 locked;

`ifdef RX_INPUT_SYNC_EN
  logic din_p0;
  logic din_p1;

  // Two-flop synchronizer for a link driven from a foreign clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
    end else begin
      din_p0 <= bus.Dserie;
      din_p1 <= din_p0;
    end
  end

  assign din = din_p1;
`else
  assign din = bus.Dserie;
`endif

  assign win       = {din, sr};
  assign fill_done = (fill_cnt == 4'd15);
  assign match     = fill_done && frame_match(win);
  assign boundary  = (bcnt == 4'd15);
  assign bcnt_clr  = (state == HUNT) && match;
  assign good_nxt  = {1'b0, good} + 4'd1;
  assign errs_nxt  = {1'b0, errs} + 4'd1;
  assign win_flags = rx_flags_t'(win[FLAG_LSB +: N_FLAGS]);

  // Shift in one bit per clk; fill count blocks matches on reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      fill_cnt <= 4'd0;
    end else begin
      sr <= win[FRAME_W-1:1];
      if (!fill_done) fill_cnt <= fill_cnt + 4'd1;
    end
  end

  frame_bit_counter u_bcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bcnt_clr),
    .en    (1'b1),
    .cnt   (bcnt)
  );

  // Alignment FSM with registered flags and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      good        <= 3'd0;
      errs        <= 3'd0;
      flags       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      unique case (state)
        HUNT: begin
          if (match) begin
            if (LOCK_FRAMES <= 1) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              flags       <= win_flags;
              frame_valid <= 1'b1;
              errs        <= 3'd0;
            end else begin
              state <= VERIFY;
              good  <= 3'd1;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (match) begin
              if (good_nxt == LOCK_N) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                flags       <= win_flags;
                frame_valid <= 1'b1;
                errs        <= 3'd0;
              end else begin
                good <= good_nxt[2:0];
              end
            end else begin
              state <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (match) begin
              flags       <= win_flags;
              frame_valid <= 1'b1;
              errs        <= 3'd0;
            end else begin
              frame_err <= 1'b1;
              if (errs_nxt >= UNLOCK_N) begin
                state  <= HUNT;
                locked <= 1'b0;
                errs   <= 3'd0;
              end else begin
                errs <= errs_nxt[2:0];
              end
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.humo        = flags.humo;
  assign bus.pos         = flags.pos;
  assign bus.tempG       = flags.tempg;
  assign bus.tempL       = flags.templ;
  assign bus.frec        = flags.frec;
  assign bus.alL         = flags.all;
  assign bus.alG         = flags.alg;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_err   = frame_err;
  assign bus.locked      = locked;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: a scoreboard queue holds the expected
// frame_valid/frame_err events (pushed as frames are driven) and a
// negedge monitor pops and compares them; scenario tasks add inline checks.
module tb_serial_frame_receiver;

`ifdef RX_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_frame_receiver_if bus ();

  serial_frame_receiver #(
    .LOCK_FRAMES (2),
    .UNLOCK_ERRS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [6:0] flags;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         sb_en    = 1'b1;
  logic [6:0] model_flags = 7'd0;

  function automatic logic [6:0] obs_flags();
    return {bus.alG, bus.alL, bus.frec, bus.tempL, bus.tempG, bus.pos, bus.humo};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sb_en && rst_n && (bus.frame_valid || bus.frame_err)) begin
      n_checks++;
      if ((bus.frame_valid & bus.frame_err) !== 1'b0)
        $display("FAIL sb_exclusive: valid=%b err=%b, required not both", bus.frame_valid, bus.frame_err);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: valid=%b err=%b flags=%b, required no event at t=%0t",
                 bus.frame_valid, bus.frame_err, obs_flags(), $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.frame_err, obs_flags()} !== {mon_e.err, mon_e.flags})
          $display("FAIL sb_event: err=%b flags=%b, required err=%b flags=%b at t=%0t",
                   bus.frame_err, obs_flags(), mon_e.err, mon_e.flags, $time);
        else n_pass++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    bus.Dserie = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [15:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_range(w, 0, 15);
  endtask

  // Expected event for a frame arriving while locked
  task automatic push_exp(input logic [15:0] w);
    ev_t e;
    if ((w & 16'hFC07) == 16'hF803) begin
      model_flags = w[9:3];
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.flags = model_flags;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Dserie = 1'b0;
    exp_q.delete();
    model_flags = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_lock();
    do_reset();
    send_frame(16'hF803);
    push_exp(16'hF803);
    send_frame(16'hF803);
  endtask

  task automatic drain(input string name);
    repeat (SL + 1) send_bit(1'b0);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Dserie = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.locked !== 1'b0) $display("FAIL rst_locked: %b, required 0", bus.locked); else n_pass++;
    n_checks++;
    if (bus.frame_valid !== 1'b0) $display("FAIL rst_valid: %b, required 0", bus.frame_valid); else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b0) $display("FAIL rst_err: %b, required 0", bus.frame_err); else n_pass++;
    n_checks++;
    if (obs_flags() !== 7'd0) $display("FAIL rst_flags: %b, required 0000000", obs_flags()); else n_pass++;
  endtask

  task automatic test_lock();
    logic [15:0] w;
    w = 16'hF803;
    do_reset();
    repeat (3) push_exp(w);
    for (int n = 1; n <= 64; n++) begin
      send_bit(w[(n - 1) % 16]);
      if (n == 31 + SL) begin
        n_checks++;
        if (bus.locked !== 1'b0) $display("FAIL lock_early: locked=%b at clk %0d, required 0", bus.locked, n);
        else n_pass++;
      end
      if (n == 32 + SL) begin
        n_checks++;
        if ({bus.locked, bus.frame_valid} !== 2'b11)
          $display("FAIL lock_at32: locked=%b valid=%b at clk %0d, required 1 1", bus.locked, bus.frame_valid, n);
        else n_pass++;
      end
    end
    drain("lock");
  endtask

  task automatic test_flags();
    do_lock();
    push_exp(16'hF80B);
    send_frame(16'hF80B);
    push_exp(16'hFBFB);
    send_range(16'hFBFB, 0, SL - 1);
    n_checks++;
    if (obs_flags() !== 7'b0000001) $display("FAIL flags_humo: %b, required 0000001", obs_flags()); else n_pass++;
    send_range(16'hFBFB, SL, 15);
    send_range(16'hF803, 0, SL - 1);
    n_checks++;
    if (obs_flags() !== 7'b1111111) $display("FAIL flags_all: %b, required 1111111", obs_flags()); else n_pass++;
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL flags_locked: %b, required 1", bus.locked); else n_pass++;
    drain("flags");
  endtask

  task automatic test_err();
    do_lock();
    push_exp(16'h7803);
    send_frame(16'h7803);
    push_exp(16'hFBFB);
    send_range(16'hFBFB, 0, SL - 1);
    n_checks++;
    if ({bus.locked, obs_flags()} !== {1'b1, 7'b0000000})
      $display("FAIL err_single: locked=%b flags=%b, required 1 0000000", bus.locked, obs_flags());
    else n_pass++;
    send_range(16'hFBFB, SL, 15);
    push_exp(16'h7803);
    send_frame(16'h7803);
    push_exp(16'h7803);
    send_frame(16'h7803);
    send_range(16'hF803, 0, SL - 1);
    n_checks++;
    if ({bus.locked, obs_flags()} !== {1'b0, 7'b1111111})
      $display("FAIL err_unlock: locked=%b flags=%b, required 0 1111111", bus.locked, obs_flags());
    else n_pass++;
    drain("err");
  endtask

  task automatic test_align();
    logic [15:0] w;
    int nv;
    int idx;
    w = 16'hFBFB;
    for (int k = 0; k < 16; k++) begin
      do_reset();
      sb_en = 1'b0;
      nv = 0;
      for (int n = 0; n < 64 + SL; n++) begin
        idx = (k + n) % 16;
        send_bit(w[idx]);
        if (bus.frame_valid || bus.frame_err) begin
          nv++;
          n_checks++;
          if ({bus.frame_err, obs_flags()} !== {1'b0, 7'b1111111} || ((idx + 16 - SL) % 8) != 7)
            $display("FAIL align_k%0d: err=%b flags=%b bit=%0d, required err=0 flags=1111111 at frame end",
                     k, bus.frame_err, obs_flags(), idx);
          else n_pass++;
        end
      end
      n_checks++;
      if (bus.locked !== 1'b1 || nv < 1)
        $display("FAIL align_lock_k%0d: locked=%b valid_count=%0d, required locked=1 count>=1", k, bus.locked, nv);
      else n_pass++;
      sb_en = 1'b1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    w = 16'hF803;
    do_lock();
    push_exp(16'hF80B);
    send_frame(16'hF80B);
    send_range(w, 0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.locked, bus.frame_valid, bus.frame_err, obs_flags()} !== 10'd0)
      $display("FAIL midrst_outputs: locked=%b valid=%b err=%b flags=%b, required all 0",
               bus.locked, bus.frame_valid, bus.frame_err, obs_flags());
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL midrst_pending: %0d events, required 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    model_flags = 7'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) push_exp(w);
    for (int n = 1; n <= 48; n++) begin
      send_bit(w[(n - 1) % 16]);
      if (n == 31 + SL) begin
        n_checks++;
        if (bus.locked !== 1'b0) $display("FAIL midrst_early: locked=%b, required 0", bus.locked); else n_pass++;
      end
      if (n == 32 + SL) begin
        n_checks++;
        if (bus.locked !== 1'b1) $display("FAIL midrst_relock: locked=%b, required 1", bus.locked); else n_pass++;
      end
    end
    drain("midrst");
  endtask

  initial begin
    bus.Dserie = 1'b0;
    test_reset();
    test_lock();
    test_flags();
    test_err();
    test_align();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
